instr_encoder: RTL

Writer-side counterpart to the instruction decode path: accepts symbolic instructions (kind code plus register/immediate fields) over a valid/ready stream, encodes each into a 32-bit MIPS word, and writes the words into instruction memory at consecutive word addresses through a buffered write port with backpressure. Used to load programs into IM before the core runs, and by benches to generate instruction streams. Its output must decode back to the same kind under the control decoder.

---
 rtl/instr_encoder_pkg.sv | 58 +++++
 rtl/encoder_fifo.sv | 54 +++++
 rtl/instr_encoder.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/instr_encoder_pkg.sv
// ----------------------------------------------------------------------------
// instr_encoder_pkg : kind codes, MIPS op/funct constants, field helpers
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package instr_encoder_pkg;

   // Symbolic kind codes, shared with the control decoder
   localparam logic [7:0] INSTR_ADDU = 8'h00;
   localparam logic [7:0] INSTR_SUBU = 8'h01;
   localparam logic [7:0] INSTR_LUI  = 8'h02;
   localparam logic [7:0] INSTR_ORI  = 8'h03;
   localparam logic [7:0] INSTR_LW   = 8'h04;
   localparam logic [7:0] INSTR_SW   = 8'h05;
   localparam logic [7:0] INSTR_BEQ  = 8'h06;
   localparam logic [7:0] INSTR_NOP  = 8'h07;

   localparam logic [5:0] INSTR_MAGIC_OP_RTYPE   = 6'h00;
   localparam logic [5:0] INSTR_MAGIC_FUNCT_ADDU = 6'h21;
   localparam logic [5:0] INSTR_MAGIC_FUNCT_SUBU = 6'h23;
   localparam logic [5:0] INSTR_MAGIC_OP_LUI     = 6'h0F;
   localparam logic [5:0] INSTR_MAGIC_OP_ORI     = 6'h0D;
   localparam logic [5:0] INSTR_MAGIC_OP_LW      = 6'h23;
   localparam logic [5:0] INSTR_MAGIC_OP_SW      = 6'h2B;
   localparam logic [5:0] INSTR_MAGIC_OP_BEQ     = 6'h04;

   localparam int FIELD_OP_LSB = 26;
   localparam int FIELD_RS_LSB = 21;
   localparam int FIELD_RT_LSB = 16;
   localparam int FIELD_RD_LSB = 11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } enc_state_t;

   typedef struct packed {
      logic        known;
      logic [31:0] word;
   } enc_result_t;

   function automatic logic [31:0] pack_rtype(input logic [4:0] rs, input logic [4:0] rt,
                                              input logic [4:0] rd, input logic [5:0] funct);
      return (32'(INSTR_MAGIC_OP_RTYPE) << FIELD_OP_LSB) | (32'(rs) << FIELD_RS_LSB) |
             (32'(rt) << FIELD_RT_LSB) | (32'(rd) << FIELD_RD_LSB) | 32'(funct);
   endfunction

   function automatic logic [31:0] pack_itype(input logic [5:0] op, input logic [4:0] rs,
                                              input logic [4:0] rt, input logic [15:0] imm);
      return (32'(op) << FIELD_OP_LSB) | (32'(rs) << FIELD_RS_LSB) |
             (32'(rt) << FIELD_RT_LSB) | 32'(imm);
   endfunction

endpackage

`default_nettype wire

// File: rtl/encoder_fifo.sv
// ----------------------------------------------------------------------------
// encoder_fifo : synchronous FIFO holding {address, encoded word} entries
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module encoder_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 42
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W:0]   r_wr_ptr;
   logic [PTR_W:0]   r_rd_ptr;
   logic             w_push_ok;
   logic             w_pop_ok;

   // Pointers carry one extra wrap bit so full and empty are distinguishable
   assign count     = r_wr_ptr - r_rd_ptr;
   assign empty     = (count == '0);
   assign full      = (count == (PTR_W+1)'(DEPTH));
   assign w_push_ok = push && !full;
   assign w_pop_ok  = pop && !empty;
   assign rd_data   = r_mem[r_rd_ptr[PTR_W-1:0]];

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + (PTR_W+1)'(1);
         if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + (PTR_W+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (w_push_ok) r_mem[r_wr_ptr[PTR_W-1:0]] <= wr_data;
   end

endmodule

`default_nettype wire

// File: rtl/instr_encoder.sv
// ----------------------------------------------------------------------------
// instr_encoder : encodes symbolic instructions and streams them into IM
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module instr_encoder
   import instr_encoder_pkg::*;
#(
   parameter int IM_ADDR_WIDTH = 10,
   parameter int FIFO_DEPTH    = 4
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     start,
   input  logic                     finish,
   input  logic [IM_ADDR_WIDTH-1:0] base_addr,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [7:0]               in_kind,
   input  logic [4:0]               in_rs,
   input  logic [4:0]               in_rt,
   input  logic [4:0]               in_rd,
   input  logic [15:0]              in_imm,
   output logic                     im_write_enable,
   output logic [IM_ADDR_WIDTH-1:0] im_write_addr,
   output logic [31:0]              im_write_data,
   input  logic                     im_write_ready,
   output logic                     busy,
   output logic                     done,
   output logic [IM_ADDR_WIDTH:0]   words_written,
   output logic                     err_unknown
);

   localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
   localparam int RES_W  = IM_ADDR_WIDTH + 2;
   localparam int FIFO_W = 32 + IM_ADDR_WIDTH;
   localparam logic [RES_W-1:0] CAPACITY = RES_W'(1) << IM_ADDR_WIDTH;

   enc_state_t               r_state;
   enc_state_t               w_state_next;
   logic [IM_ADDR_WIDTH-1:0] r_base;
   logic [IM_ADDR_WIDTH:0]   r_words_written;
   logic                     r_err_unknown;

   logic                     w_fifo_full;
   logic                     w_fifo_empty;
   logic [CNT_W-1:0]         w_fifo_count;
   logic [FIFO_W-1:0]        w_fifo_rd_data;
   logic [FIFO_W-1:0]        w_fifo_wr_data;
   logic [RES_W-1:0]         w_reserved;
   logic [IM_ADDR_WIDTH-1:0] w_push_addr;
   logic                     w_accept;
   logic                     w_push;
   logic                     w_pop;
   enc_result_t              w_enc;

   function automatic enc_result_t encode_instr(input logic [7:0]  kind,
                                                input logic [4:0]  rs,
                                                input logic [4:0]  rt,
                                                input logic [4:0]  rd,
                                                input logic [15:0] imm);
      enc_result_t res;
      res.known = 1'b1;
      res.word  = '0;
      case (kind)
         INSTR_ADDU: res.word = pack_rtype(rs, rt, rd, INSTR_MAGIC_FUNCT_ADDU);
         INSTR_SUBU: res.word = pack_rtype(rs, rt, rd, INSTR_MAGIC_FUNCT_SUBU);
         INSTR_LUI:  res.word = pack_itype(INSTR_MAGIC_OP_LUI, 5'd0, rt, imm);
         INSTR_ORI:  res.word = pack_itype(INSTR_MAGIC_OP_ORI, rs, rt, imm);
         INSTR_LW:   res.word = pack_itype(INSTR_MAGIC_OP_LW, rs, rt, imm);
         INSTR_SW:   res.word = pack_itype(INSTR_MAGIC_OP_SW, rs, rt, imm);
         INSTR_BEQ:  res.word = pack_itype(INSTR_MAGIC_OP_BEQ, rs, rt, imm);
         INSTR_NOP:  res.word = '0;
         default:    res.known = 1'b0;
      endcase
      return res;
   endfunction

   assign w_enc = encode_instr(in_kind, in_rs, in_rt, in_rd, in_imm);

   // Words already committed plus those queued; the next word lands just past them
   assign w_reserved     = RES_W'(r_words_written) + RES_W'(w_fifo_count);
   assign w_push_addr    = r_base + w_reserved[IM_ADDR_WIDTH-1:0];
   assign w_fifo_wr_data = {w_push_addr, w_enc.word};
   assign w_accept       = in_valid && in_ready;
   assign w_push         = w_accept && w_enc.known;
   assign w_pop          = im_write_enable && im_write_ready;

   encoder_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (FIFO_W)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (w_push),
      .wr_data (w_fifo_wr_data),
      .pop     (w_pop),
      .rd_data (w_fifo_rd_data),
      .full    (w_fifo_full),
      .empty   (w_fifo_empty),
      .count   (w_fifo_count)
   );

   always_comb begin
      w_state_next    = r_state;
      in_ready        = 1'b0;
      im_write_enable = 1'b0;
      done            = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) w_state_next = ST_RUN;
         end
         ST_RUN: begin
            in_ready        = !w_fifo_full && (w_reserved < CAPACITY);
            im_write_enable = !w_fifo_empty;
            if (finish) w_state_next = ST_DRAIN;
         end
         ST_DRAIN: begin
            im_write_enable = !w_fifo_empty;
            if (w_fifo_empty) begin
               done         = 1'b1;
               w_state_next = ST_IDLE;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state         <= ST_IDLE;
         r_base          <= '0;
         r_words_written <= '0;
         r_err_unknown   <= 1'b0;
      end else begin
         r_state <= w_state_next;
         if (r_state == ST_IDLE && start) begin
            r_base          <= base_addr;
            r_words_written <= '0;
            r_err_unknown   <= 1'b0;
         end else begin
            if (w_pop) r_words_written <= r_words_written + (IM_ADDR_WIDTH+1)'(1);
            if (w_accept && !w_enc.known) r_err_unknown <= 1'b1;
         end
      end
   end

   // Head entry is masked so the port reads zero whenever nothing is offered
   assign im_write_addr = im_write_enable ? w_fifo_rd_data[FIFO_W-1:32] : '0;
   assign im_write_data = im_write_enable ? w_fifo_rd_data[31:0] : '0;
   assign busy          = (r_state != ST_IDLE);
   assign words_written = r_words_written;
   assign err_unknown   = r_err_unknown;

endmodule

`default_nettype wire
